// File: rtl/mem_stream_reader.sv
// Read-side sequencer for a coefficient RAM that has an asynchronous read port.
// A start pulse latches base_addr and deg. The block then walks the RAM from
// base_addr for deg+1 words, wrapping at the top of the address space, and
// streams each word out over a valid/ready handshake together with its index.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle request, sampled only in IDLE
//   base_addr, deg      first address and highest index of the pass
//   rd_addr / rd_data   RAM read address (registered) and combinational read data
//   out_valid/out_ready stream handshake
//   out_data/out_index/out_last  beat payload
//   busy                high whenever the FSM is not in IDLE
//   done                one-cycle pulse after the last beat is accepted
module mem_stream_reader #(
    parameter int unsigned RAM_WIDTH     = 26,
    parameter int unsigned RAM_ADDR_BITS = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [RAM_ADDR_BITS-1:0] base_addr,
    input  logic [RAM_ADDR_BITS-1:0] deg,
    output logic [RAM_ADDR_BITS-1:0] rd_addr,
    input  logic [RAM_WIDTH-1:0]     rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RAM_WIDTH-1:0]     out_data,
    output logic [RAM_ADDR_BITS-1:0] out_index,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    // One extra counter bit so deg = 2**RAM_ADDR_BITS-1 covers the whole RAM.
    localparam int unsigned CNT_W = RAM_ADDR_BITS + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    logic [RAM_ADDR_BITS-1:0] base_q;
    logic [RAM_ADDR_BITS-1:0] deg_q;

    logic [CNT_W-1:0] cnt_inc_c;
    logic             issue_c;

    // Issue a new beat when words remain and the output register is free.
    always_comb begin
        cnt_inc_c = cnt + CNT_W'(1);
        issue_c   = (state == S_STREAM) && (cnt <= CNT_W'(deg_q))
                    && (!out_valid || out_ready);
    end

    // Sequencer: rd_addr is kept equal to base_q + cnt so the RAM sees it from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            base_q    <= '0;
            deg_q     <= '0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        deg_q   <= deg;
                        cnt     <= '0;
                        rd_addr <= base_addr;
                        busy    <= 1'b1;
                        state   <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (issue_c) begin
                        out_data  <= rd_data;
                        out_index <= cnt[RAM_ADDR_BITS-1:0];
                        out_last  <= (cnt == CNT_W'(deg_q));
                        out_valid <= 1'b1;
                        cnt       <= cnt_inc_c;
                        rd_addr   <= base_q + cnt_inc_c[RAM_ADDR_BITS-1:0];
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                    // The last beat leaves no words to issue, so out_valid clears above.
                    if (out_valid && out_ready && out_last) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Self-checking bench for mem_stream_reader: a RAM array drives rd_data and
// the expected stream is computed directly from the RAM contents, base and deg.
module tb_mem_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [10:0] base_addr;
    logic [10:0] deg;
    logic [10:0] rd_addr;
    logic [25:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] out_data;
    logic [10:0] out_index;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [25:0] ram [0:2047];
    assign rd_data = ram[rd_addr];

    always #5 clk = ~clk;

    mem_stream_reader #(.RAM_WIDTH(26), .RAM_ADDR_BITS(11)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .deg(deg),
        .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last),
        .busy(busy), .done(done)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Observations from the most recent pass.
    logic [25:0] g_data [$];
    logic [10:0] g_idx  [$];
    logic        g_last [$];
    int first_valid, done_cnt, done_at, last_acc, hold_err, busy_at_done, busy_after, addr_c1;

    // Reference: beat i of a pass carries the RAM word at (base+i) mod 2048.
    function automatic logic [25:0] exp_data(input logic [10:0] b, input int i);
        logic [10:0] a;
        a = b + 11'(i);
        return ram[a];
    endfunction

    function automatic logic ready_val(input int mode, input int cyc);
        logic [5:0] pat;
        pat = 6'b101001;  // 1,0,0,1,0,1 from bit 0 upward
        case (mode)
            0:       return 1'b1;
            1:       return 1'($urandom_range(0, 1));
            default: return pat[cyc % 6];
        endcase
    endfunction

    // Runs one pass starting next cycle (cycle 0 = start high) and records what happened.
    task automatic run_pass(input logic [10:0] b, input logic [10:0] d, input int mode,
                            input int restart_at);
        bit          prev_stall;
        bit          fin;
        logic [25:0] pd;
        logic [10:0] pi;
        logic        pl;
        g_data.delete(); g_idx.delete(); g_last.delete();
        first_valid = -1; done_cnt = 0; done_at = -1; last_acc = -1; hold_err = 0;
        busy_at_done = -1; busy_after = -1; addr_c1 = -1;
        prev_stall = 0; fin = 0; pd = '0; pi = '0; pl = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; deg = d; out_ready = ready_val(mode, 0);
        for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
            @(negedge clk);
            if (cyc == 1) addr_c1 = int'(rd_addr);
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (prev_stall && (!out_valid || out_data !== pd || out_index !== pi || out_last !== pl))
                hold_err++;
            prev_stall = out_valid && !out_ready;
            pd = out_data; pi = out_index; pl = out_last;
            if (out_valid && out_ready) begin
                g_data.push_back(out_data); g_idx.push_back(out_index); g_last.push_back(out_last);
                last_acc = cyc;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin done_at = cyc; busy_at_done = int'(busy); end
            end
            if (done_at >= 0 && cyc == done_at + 1) busy_after = int'(busy);
            if (done_at >= 0 && cyc == done_at + 3) fin = 1;
            @(posedge clk); #1;
            if (cyc + 1 == restart_at) begin
                start = 1'b1; base_addr = 11'($urandom); deg = 11'($urandom);
            end else begin
                start = 1'b0;
            end
            out_ready = ready_val(mode, cyc + 1);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; base_addr = '0; deg = '0; out_ready = 1'b0;
        #12;
        n_total++;
        if ({out_valid, out_data, out_index, out_last, busy, done, rd_addr} !== '0)
            $display("FAIL reset_outputs: got valid=%0d data=%0d idx=%0d last=%0d busy=%0d done=%0d addr=%0d, want all 0",
                     out_valid, out_data, out_index, out_last, busy, done, rd_addr);
        else n_pass++;
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({out_valid, busy, done, rd_addr} !== '0)
            $display("FAIL idle_after_reset: got valid=%0d busy=%0d done=%0d addr=%0d, want 0",
                     out_valid, busy, done, rd_addr);
        else n_pass++;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) ram[i] = 26'(i + 100);
        run_pass(11'd0, 11'd3, 0, -1);
        n_total++;
        if (g_data.size() !== 4) $display("FAIL basic_count: got %0d want 4", g_data.size());
        else n_pass++;
        for (int i = 0; i < g_data.size(); i++) begin
            n_total++;
            if (g_data[i] !== 26'(i + 100) || g_idx[i] !== 11'(i) || g_last[i] !== (i == 3))
                $display("FAIL basic_beat%0d: got data=%0d idx=%0d last=%0d want %0d/%0d/%0d",
                         i, g_data[i], g_idx[i], g_last[i], i + 100, i, (i == 3));
            else n_pass++;
        end
        n_total++;
        if (first_valid !== 2 || last_acc !== 5)
            $display("FAIL basic_timing: got first=%0d last=%0d want 2/5", first_valid, last_acc);
        else n_pass++;
        n_total++;
        if (done_at !== 6 || done_cnt !== 1 || busy_at_done !== 1 || busy_after !== 0)
            $display("FAIL basic_done: got at=%0d cnt=%0d busy@done=%0d busy_after=%0d want 6/1/1/0",
                     done_at, done_cnt, busy_at_done, busy_after);
        else n_pass++;
    endtask

    task automatic test_wrap();
        ram[2046] = 26'h0AAAAAA; ram[2047] = 26'h1BBBBBB; ram[0] = 26'h2CCCCCC; ram[1] = 26'h3DDDDDD;
        run_pass(11'd2046, 11'd3, 0, -1);
        n_total++;
        if (addr_c1 !== 2046) $display("FAIL wrap_first_addr: got %0d want 2046", addr_c1);
        else n_pass++;
        n_total++;
        if (g_data.size() !== 4) $display("FAIL wrap_count: got %0d want 4", g_data.size());
        else n_pass++;
        for (int i = 0; i < g_data.size(); i++) begin
            n_total++;
            if (g_data[i] !== exp_data(11'd2046, i) || g_idx[i] !== 11'(i))
                $display("FAIL wrap_beat%0d: got data=%h idx=%0d want %h/%0d",
                         i, g_data[i], g_idx[i], exp_data(11'd2046, i), i);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [10:0] b;
        logic [10:0] d;
        for (int iter = 0; iter < 5; iter++) begin
            b = 11'($urandom);
            d = (iter == 0) ? 11'd5 : 11'($urandom_range(0, 40));
            run_pass(b, d, (iter == 0) ? 2 : 1, -1);
            n_total++;
            if (g_data.size() !== int'(d) + 1 || hold_err !== 0 || done_cnt !== 1)
                $display("FAIL bp%0d_summary: got beats=%0d hold_err=%0d done=%0d want %0d/0/1",
                         iter, g_data.size(), hold_err, done_cnt, int'(d) + 1);
            else n_pass++;
            for (int i = 0; i < g_data.size(); i++) begin
                n_total++;
                if (g_data[i] !== exp_data(b, i) || g_idx[i] !== 11'(i) || g_last[i] !== (i == int'(d)))
                    $display("FAIL bp%0d_beat%0d: got data=%h idx=%0d last=%0d want %h/%0d/%0d",
                             iter, i, g_data[i], g_idx[i], g_last[i], exp_data(b, i), i, (i == int'(d)));
                else n_pass++;
            end
        end
    endtask

    task automatic test_deg_zero();
        logic [10:0] b;
        b = 11'($urandom);
        run_pass(b, 11'd0, 0, -1);
        n_total++;
        if (g_data.size() !== 1) $display("FAIL deg0_count: got %0d want 1", g_data.size());
        else if (g_data[0] !== ram[b] || g_idx[0] !== 11'd0 || g_last[0] !== 1'b1)
            $display("FAIL deg0_beat: got data=%h idx=%0d last=%0d want %h/0/1",
                     g_data[0], g_idx[0], g_last[0], ram[b]);
        else n_pass++;
        n_total++;
        if (done_at !== 3 || done_cnt !== 1)
            $display("FAIL deg0_done: got at=%0d cnt=%0d want 3/1", done_at, done_cnt);
        else n_pass++;
    endtask

    task automatic test_full();
        int bad;
        bad = 0;
        run_pass(11'd5, 11'd2047, 0, -1);
        n_total++;
        if (g_data.size() !== 2048) $display("FAIL full_count: got %0d want 2048", g_data.size());
        else n_pass++;
        for (int i = 0; i < g_data.size(); i++)
            if (g_data[i] !== exp_data(11'd5, i) || g_idx[i] !== 11'(i) || g_last[i] !== (i == 2047))
                bad++;
        n_total++;
        if (bad !== 0) $display("FAIL full_beats: got %0d wrong beats want 0", bad);
        else n_pass++;
        n_total++;
        if (g_data.size() != 2048 || g_data[2047] !== ram[4])
            $display("FAIL full_last_addr: got last data=%h want ram[4]=%h",
                     (g_data.size() == 2048) ? g_data[2047] : 26'h0, ram[4]);
        else n_pass++;
        n_total++;
        if (done_at !== 2050) $display("FAIL full_done: got %0d want 2050", done_at);
        else n_pass++;
    endtask

    task automatic test_restart_ignored();
        run_pass(11'd100, 11'd9, 1, 4);
        n_total++;
        if (g_data.size() !== 10 || done_cnt !== 1)
            $display("FAIL restart_count: got beats=%0d done=%0d want 10/1", g_data.size(), done_cnt);
        else n_pass++;
        for (int i = 0; i < g_data.size(); i++) begin
            n_total++;
            if (g_data[i] !== exp_data(11'd100, i) || g_idx[i] !== 11'(i))
                $display("FAIL restart_beat%0d: got data=%h idx=%0d want %h/%0d",
                         i, g_data[i], g_idx[i], exp_data(11'd100, i), i);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        bit done_seen;
        found = 0; done_seen = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 11'd300; deg = 11'd7; out_ready = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (out_valid && out_index == 11'd2) found = 1;
        end
        n_total++;
        if (!found) $display("FAIL rstmid_reach_beat2: got no beat 2 within 20 cycles want beat 2");
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({out_valid, busy, done, rd_addr, out_index, out_last, out_data} !== '0)
            $display("FAIL rstmid_async_clear: got valid=%0d busy=%0d done=%0d addr=%0d idx=%0d want 0",
                     out_valid, busy, done, rd_addr, out_index);
        else n_pass++;
        @(posedge clk); #1; rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done === 1'b1 || out_valid === 1'b1) done_seen = 1;
        end
        n_total++;
        if (done_seen) $display("FAIL rstmid_no_done: got done/valid after reset want none");
        else n_pass++;
        run_pass(11'd500, 11'd7, 0, -1);
        n_total++;
        if (g_data.size() !== 8 || first_valid !== 2 || done_cnt !== 1)
            $display("FAIL rstmid_clean_pass: got beats=%0d first=%0d done=%0d want 8/2/1",
                     g_data.size(), first_valid, done_cnt);
        else n_pass++;
        for (int i = 0; i < g_data.size(); i++) begin
            n_total++;
            if (g_data[i] !== exp_data(11'd500, i) || g_idx[i] !== 11'(i))
                $display("FAIL rstmid_beat%0d: got data=%h idx=%0d want %h/%0d",
                         i, g_data[i], g_idx[i], exp_data(11'd500, i), i);
            else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = 26'($urandom);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_deg_zero();
        test_full();
        test_restart_ignored();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
